// File: rtl/ram_pkg.sv
// Shared types and default widths for the CPU data RAM, plus the parity helper.
package ram_pkg;

  typedef enum logic {CLEAR, IDLE} ram_state_t;

  localparam int RAM_DATA_W = 4;
  localparam int RAM_ADDR_W = 4;

  // The caller zero-extends its word, so any width up to 64 bits fits.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM. It clears every cell after reset and has a
// registered read. Optional parity storage and checking: define RAM_PARITY_EN.
module sync_ram
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int CELL_W = DATA_W + 1;
`else
  localparam int CELL_W = DATA_W;
`endif

  logic [CELL_W-1:0] r_mem [DEPTH];
  ram_state_t        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_ready;
  logic [CELL_W-1:0] w_wr_word;
  logic [CELL_W-1:0] w_rd_word;

`ifdef RAM_PARITY_EN
  logic r_par_err;
  assign w_wr_word = {even_parity(64'(data_in)), data_in};
  assign par_err   = r_par_err;
`else
  assign w_wr_word = data_in;
  assign par_err   = 1'b0;
`endif

  assign w_rd_word = r_mem[addr];

  // Array port: the clear sequencer owns it until IDLE. Nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == CLEAR)
        r_mem[r_clr_addr] <= '0;
      else if (cs && write_en)
        r_mem[addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_ready    <= 1'b0;
`ifdef RAM_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == '1) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        IDLE: begin
          r_ready <= 1'b1;
          if (cs && !write_en) begin
            r_data_out <= w_rd_word[DATA_W-1:0];
            r_rd_valid <= 1'b1;
`ifdef RAM_PARITY_EN
            r_par_err  <= ^w_rd_word;
`endif
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign ready    = r_ready;

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboard bench for sync_ram (DATA_W=4, ADDR_W=4). Define RAM_PARITY_EN to exercise the parity path.
module tb_sync_ram;

  logic       clk = 1'b0;
  logic       rst_n, cs, write_en;
  logic [3:0] addr, data_in, data_out;
  logic       rd_valid, ready, par_err;

  logic [3:0] model [16];
  logic [4:0] sb_q [$];
  int         n_err = 0;
  int         n_chk = 0;
  int         n_valid = 0;

  sync_ram #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .write_en(write_en), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .ready(ready), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every read pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [4:0] e;
    if (rd_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check("rd_spurious", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rd_data", 32'(data_out), 32'(e[3:0]));
        check("rd_par", 32'(par_err), 32'(e[4]));
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    cs = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    model[a] = d;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic par);
    cs = 1'b1; write_en = 1'b0; addr = a;
    sb_q.push_back({par, model[a]});
    step();
  endtask

  task automatic idle(input int n);
    cs = 1'b0; write_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_clear(input bit stray_write);
    int cnt;
    rst_n = 1'b0; cs = stray_write; write_en = 1'b1; addr = 4'd2; data_in = 4'd5;
    step(); step();
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_par", 32'(par_err), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!ready && cnt < 100);
    check("clear_len", 32'(cnt), 32'd16);
    cs = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 4'd0;
  endtask

  initial begin
    int v0;
    int w;
    rst_n = 1'b0; cs = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;

    // Reset, clear length, and a write held throughout CLEAR that must be ignored.
    reset_clear(1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), 1'b0);
    idle(2);

    // Read-after-write on the next cycle.
    wr(4'd3, 4'hA);
    rd(4'd3, 1'b0);
    idle(2);

    // Fill and back-to-back reads.
    for (int i = 0; i < 15; i++) wr(4'(i), 4'(i + 1));
    v0 = n_valid;
    for (int i = 0; i < 15; i++) rd(4'(i), 1'b0);
    idle(3);
    check("b2b_count", 32'(n_valid - v0), 32'd15);
    check("hold_dout", 32'(data_out), 32'hF);

`ifdef RAM_PARITY_EN
    dut.r_mem[7][0] = ~dut.r_mem[7][0];
    model[7] = model[7] ^ 4'd1;
    rd(4'd7, 1'b1);
    rd(4'd8, 1'b0);
    idle(2);
`endif

    // Reset coinciding with the edge that would capture a read.
    cs = 1'b1; write_en = 1'b0; addr = 4'd3; rst_n = 1'b0;
    step();
    check("rst_drop_valid", 32'(rd_valid), 32'd0);
    check("rst_drop_ready", 32'(ready), 32'd0);
    reset_clear(1'b0);
    rd(4'd3, 1'b0);
    rd(4'd14, 1'b0);
    idle(2);

    w = 0;
    while (sb_q.size() != 0 && w < 10) begin
      step();
      w++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
